// File: rtl/screen_seq_ctl_pkg.sv
// Shared encodings for the screen sequencer: screen codes, command set,
// menu button regions and the colour palette.
package screen_seq_ctl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GAME    = 2'd1,
      CREDITS = 2'd2
   } screen_t;

   typedef enum logic [2:0] {
      CMD_NONE  = 3'd0,
      CMD_START = 3'd1,
      CMD_DIFF  = 3'd2,
      CMD_COLOR = 3'd3,
      CMD_CRED  = 3'd4,
      CMD_BACK  = 3'd5
   } cmd_e;

   // All menu buttons share one column; bounds are inclusive.
   localparam logic [11:0] REGION_X_LO  = 12'd362;
   localparam logic [11:0] REGION_X_HI  = 12'd674;
   localparam logic [11:0] START_Y_LO   = 12'd46;
   localparam logic [11:0] START_Y_HI   = 12'd146;
   localparam logic [11:0] DIFF_Y_LO    = 12'd238;
   localparam logic [11:0] DIFF_Y_HI    = 12'd338;
   localparam logic [11:0] COLOR_Y_LO   = 12'd430;
   localparam logic [11:0] COLOR_Y_HI   = 12'd530;
   localparam logic [11:0] CRED_Y_LO    = 12'd622;
   localparam logic [11:0] CRED_Y_HI    = 12'd722;

   localparam logic [2:0] COLOR_MAX = 3'd6;

   // {background, foreground}, entry 7 listed first; 7 is unreachable.
   localparam logic [7:0][23:0] PALETTE = {
      24'h000FFF, 24'h090F6F, 24'h9006FF, 24'h009FF6,
      24'h99066F, 24'h9096F6, 24'h099F66, 24'h000FFF
   };

   function automatic logic [23:0] palette_lookup(input logic [2:0] idx);
      return PALETTE[idx];
   endfunction

   function automatic logic in_range(input logic [11:0] v,
                                     input logic [11:0] lo,
                                     input logic [11:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

   function automatic cmd_e hit_test(input logic [11:0] x, input logic [11:0] y);
      cmd_e c;
      c = CMD_NONE;
      if (in_range(x, REGION_X_LO, REGION_X_HI)) begin
         if (in_range(y, START_Y_LO, START_Y_HI))      c = CMD_START;
         else if (in_range(y, DIFF_Y_LO, DIFF_Y_HI))   c = CMD_DIFF;
         else if (in_range(y, COLOR_Y_LO, COLOR_Y_HI)) c = CMD_COLOR;
         else if (in_range(y, CRED_Y_LO, CRED_Y_HI))   c = CMD_CRED;
      end
      return c;
   endfunction

endpackage

// File: rtl/screen_seq_ctl_if.sv
// Bundle of the sequencer's inputs and committed outputs.
// There is no valid/ready handshake: inputs are levels sampled every clk and
// outputs are registered state that holds until the next commit.
interface screen_seq_ctl_if;
   import screen_seq_ctl_pkg::*;

   logic        vblnk_in;
   logic [11:0] xpos;
   logic [11:0] ypos;
   logic        mouse_left;
   logic        button;
   logic [1:0]  screen;
   logic        difficulty;
   logic [2:0]  color_state;
   logic [11:0] color1;
   logic [11:0] color2;
   logic        cmd_pending;
   cmd_e        dbg_cmd;

   modport master (
      output vblnk_in, xpos, ypos, mouse_left, button,
      input  screen, difficulty, color_state, color1, color2, cmd_pending, dbg_cmd
   );

   modport slave (
      input  vblnk_in, xpos, ypos, mouse_left, button,
      output screen, difficulty, color_state, color1, color2, cmd_pending, dbg_cmd
   );

endinterface

// File: rtl/screen_seq_ctl_edge_holdoff.sv
// Rising-edge detector with a holdoff window: an accepted edge blocks
// further edges for HOLDOFF cycles. Blocked edges are dropped, not queued.
module edge_holdoff #(
   parameter int HOLDOFF = 650000
) (
   input  logic clk,
   input  logic rst,
   input  logic level,
   input  logic enable,
   output logic accept
);

   localparam int CW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(HOLDOFF - 1);

   logic          level_q;
   logic [CW-1:0] cnt;

   // A disabled edge must not arm the window.
   assign accept = level & ~level_q & (cnt == '0) & enable;

   always_ff @(posedge clk) begin
      if (rst) begin
         level_q <= 1'b0;
         cnt     <= '0;
      end else begin
         level_q <= level;
         if (accept)
            cnt <= RELOAD;
         else if (cnt != '0)
            cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/screen_seq_ctl.sv
// Frame-synchronous command sequencer: debounced clicks/button edges latch
// one command, which is committed at the next rising edge of vblnk_in.
module screen_seq_ctl
   import screen_seq_ctl_pkg::*;
#(
   parameter int HOLDOFF = 650000
) (
   input logic             clk,
   input logic             rst,
   screen_seq_ctl_if.slave bus
);

   logic        click_acc;
   logic        back_acc;
   logic        vblnk_q;
   logic        frame_start;
   screen_t     scr;
   cmd_e        pending;
   cmd_e        new_cmd;
   logic        diff_r;
   logic [2:0]  col;
   logic [11:0] color1_r;
   logic [11:0] color2_r;

   edge_holdoff #(.HOLDOFF(HOLDOFF)) u_click (
      .clk    (clk),
      .rst    (rst),
      .level  (bus.mouse_left),
      .enable (1'b1),
      .accept (click_acc)
   );

   // The button only means BACK outside the menu; in IDLE it is ignored entirely.
   edge_holdoff #(.HOLDOFF(HOLDOFF)) u_back (
      .clk    (clk),
      .rst    (rst),
      .level  (bus.button),
      .enable (scr != IDLE),
      .accept (back_acc)
   );

   assign frame_start = bus.vblnk_in & ~vblnk_q;

   always_comb begin
      new_cmd = CMD_NONE;
      if (click_acc && (scr == IDLE))
         new_cmd = hit_test(bus.xpos, bus.ypos);
      else if (back_acc)
         new_cmd = CMD_BACK;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vblnk_q  <= 1'b0;
         scr      <= IDLE;
         pending  <= CMD_NONE;
         diff_r   <= 1'b0;
         col      <= 3'd0;
         color1_r <= 12'h000;
         color2_r <= 12'hFFF;
      end else begin
         vblnk_q <= bus.vblnk_in;
         if (frame_start) begin
            case (pending)
               CMD_START: if (scr == IDLE) scr <= GAME;
               CMD_CRED:  if (scr == IDLE) scr <= CREDITS;
               CMD_BACK:  if (scr != IDLE) scr <= IDLE;
               CMD_DIFF:  diff_r <= ~diff_r;
               CMD_COLOR: col <= (col == COLOR_MAX) ? 3'd0 : col + 3'd1;
               default:   ;
            endcase
         end
         // A commit frees the slot in the same cycle, so a coincident edge latches.
         if (frame_start || (pending == CMD_NONE))
            pending <= new_cmd;
         {color1_r, color2_r} <= palette_lookup(col);
      end
   end

   assign bus.screen      = scr;
   assign bus.difficulty  = diff_r;
   assign bus.color_state = col;
   assign bus.color1      = color1_r;
   assign bus.color2      = color2_r;
   assign bus.cmd_pending = (pending != CMD_NONE);
   assign bus.dbg_cmd     = pending;

endmodule

// File: tb/tb_screen_seq_ctl.sv
// Directed bench for screen_seq_ctl: every output change is popped from an
// expected queue filled by the driver as it issues stimulus.
module tb_screen_seq_ctl;

   localparam int HOLDOFF = 16;
   localparam int W = 31;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   screen_seq_ctl_if bus();

   screen_seq_ctl #(.HOLDOFF(HOLDOFF)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [11:0] exp_bg [7] = '{12'h000, 12'h099, 12'h909, 12'h990, 12'h009, 12'h900, 12'h090};
   logic [11:0] exp_fg [7] = '{12'hFFF, 12'hF66, 12'h6F6, 12'h66F, 12'hFF6, 12'h6FF, 12'hF6F};

   logic [W-1:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   logic [1:0]  m_scr;
   logic        m_dif;
   logic [2:0]  m_col;
   logic [11:0] m_c1;
   logic [11:0] m_c2;
   logic        m_pend;

   function automatic string fmt(input logic [W-1:0] v);
      return $sformatf("scr=%0d dif=%0d col=%0d c1=%03h c2=%03h pend=%0d",
                       v[30:29], v[28], v[27:25], v[24:13], v[12:1], v[0]);
   endfunction

   task automatic push_exp();
      exp_q.push_back({m_scr, m_dif, m_col, m_c1, m_c2, m_pend});
   endtask

   task automatic model_reset();
      m_scr = 2'd0; m_dif = 1'b0; m_col = 3'd0;
      m_c1 = 12'h000; m_c2 = 12'hFFF; m_pend = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press_mouse(input int x, input int y);
      bus.xpos = 12'(x);
      bus.ypos = 12'(y);
      bus.mouse_left = 1'b1;
      tick(2);
      bus.mouse_left = 1'b0;
      tick(1);
   endtask

   task automatic click_gap(input int x, input int y);
      press_mouse(x, y);
      tick(HOLDOFF + 4);
   endtask

   task automatic press_button();
      bus.button = 1'b1;
      tick(2);
      bus.button = 1'b0;
      tick(HOLDOFF + 4);
   endtask

   task automatic vblank();
      bus.vblnk_in = 1'b1;
      tick(3);
      bus.vblnk_in = 1'b0;
      tick(4);
   endtask

   // COLOR commit: state and pending change at the frame edge, palette one cycle later.
   task automatic expect_color_commit();
      m_col = (m_col == 3'd6) ? 3'd0 : m_col + 3'd1;
      m_pend = 1'b0;
      push_exp();
      m_c1 = exp_bg[m_col];
      m_c2 = exp_fg[m_col];
      push_exp();
   endtask

   // Monitor: first sample after reset is always checked, then every change.
   logic [W-1:0] prev;
   logic [W-1:0] cur;
   logic [W-1:0] exp_v;
   logic after_rst = 1'b1;

   always @(negedge clk) begin
      cur = {bus.screen, bus.difficulty, bus.color_state, bus.color1, bus.color2, bus.cmd_pending};
      if (rst) begin
         after_rst = 1'b1;
      end else if (after_rst || (cur != prev)) begin
         after_rst = 1'b0;
         prev = cur;
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_change t=%0t: got %s, required no change", $time, fmt(cur));
         end else begin
            exp_v = exp_q.pop_front();
            if (cur !== exp_v) begin
               n_err++;
               $display("FAIL output_state t=%0t: got %s, required %s", $time, fmt(cur), fmt(exp_v));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      bus.vblnk_in = 1'b0;
      bus.xpos = 12'd0;
      bus.ypos = 12'd0;
      bus.mouse_left = 1'b0;
      bus.button = 1'b0;
      rst = 1'b1;
      model_reset();
      push_exp();
      tick(3);
      rst = 1'b0;
      tick(2);

      // Held click on DIFF across three frames toggles once.
      m_pend = 1'b1; push_exp();
      bus.xpos = 12'd500; bus.ypos = 12'd300; bus.mouse_left = 1'b1;
      tick(4);
      m_dif = 1'b1; m_pend = 1'b0; push_exp();
      vblank(); vblank(); vblank();
      bus.mouse_left = 1'b0;
      tick(HOLDOFF + 4);

      // Two COLOR clicks in one frame: the second is dropped while pending.
      m_pend = 1'b1; push_exp();
      click_gap(362, 430);
      click_gap(674, 530);
      expect_color_commit();
      vblank();
      vblank();

      // Walk the palette up to 6, then seven more clicks wrap back to 6.
      for (int k = 0; k < 12; k++) begin
         m_pend = 1'b1; push_exp();
         click_gap(500, 480);
         expect_color_commit();
         vblank();
      end

      // Just outside the regions: nothing latches. Button in IDLE is ignored.
      click_gap(361, 430);
      click_gap(675, 300);
      click_gap(500, 147);
      click_gap(500, 237);
      click_gap(500, 723);
      press_button();
      vblank();

      // Corner of CRED, then back to menu.
      m_pend = 1'b1; push_exp();
      click_gap(674, 722);
      m_scr = 2'd2; m_pend = 1'b0; push_exp();
      vblank();
      m_pend = 1'b1; push_exp();
      press_button();
      m_scr = 2'd0; m_pend = 1'b0; push_exp();
      vblank();

      // START on the same cycle as the vblank rise commits a frame later.
      m_pend = 1'b1; push_exp();
      bus.xpos = 12'd500; bus.ypos = 12'd100;
      bus.mouse_left = 1'b1; bus.vblnk_in = 1'b1;
      tick(3);
      bus.mouse_left = 1'b0; bus.vblnk_in = 1'b0;
      tick(HOLDOFF + 4);
      m_scr = 2'd1; m_pend = 1'b0; push_exp();
      vblank();
      m_pend = 1'b1; push_exp();
      press_button();
      m_scr = 2'd0; m_pend = 1'b0; push_exp();
      vblank();

      // Clicks inside GAME latch nothing.
      m_pend = 1'b1; push_exp();
      click_gap(500, 100);
      m_scr = 2'd1; m_pend = 1'b0; push_exp();
      vblank();
      click_gap(500, 100);
      click_gap(500, 300);
      vblank();
      m_pend = 1'b1; push_exp();
      press_button();
      m_scr = 2'd0; m_pend = 1'b0; push_exp();
      vblank();

      // Commit of DIFF and a new COLOR click in the same cycle: pending stays high.
      m_pend = 1'b1; push_exp();
      click_gap(500, 300);
      m_dif = ~m_dif; push_exp();
      bus.xpos = 12'd500; bus.ypos = 12'd480;
      bus.mouse_left = 1'b1; bus.vblnk_in = 1'b1;
      tick(3);
      bus.mouse_left = 1'b0; bus.vblnk_in = 1'b0;
      tick(HOLDOFF + 4);
      expect_color_commit();
      vblank();

      // Reset with a pending command and live holdoff, then click right after release.
      m_pend = 1'b1; push_exp();
      bus.xpos = 12'd500; bus.ypos = 12'd300; bus.mouse_left = 1'b1;
      tick(3);
      bus.mouse_left = 1'b0;
      rst = 1'b1;
      model_reset();
      push_exp();
      tick(2);
      m_pend = 1'b1; push_exp();
      bus.xpos = 12'd500; bus.ypos = 12'd100; bus.mouse_left = 1'b1;
      rst = 1'b0;
      tick(3);
      bus.mouse_left = 1'b0;
      tick(HOLDOFF);
      m_scr = 2'd1; m_pend = 1'b0; push_exp();
      vblank();

      tick(10);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL expected_drain: got %0d entries left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
